// File: rtl/feature_reduce_tree.sv
// Pipelined signed add/subtract reduction of NUM_FEATURES features to one, with a global stall.
// Optional output saturation is built when FEATURE_REDUCE_SAT_EN is defined; otherwise the sum wraps.
module feature_reduce_tree #(
  parameter int unsigned                FEATURE_WIDTH = 16,
  parameter int unsigned                NUM_FEATURES  = 6,
  parameter logic [NUM_FEATURES-1:0]    SIGN_MASK     = 6'b000011
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [FEATURE_WIDTH-1:0] features_in [0:NUM_FEATURES-1],
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [FEATURE_WIDTH-1:0] feature_out,
  output logic                            sat_hit
);

  localparam int unsigned LEVELS = $clog2(NUM_FEATURES);
  localparam int unsigned ACC_W  = FEATURE_WIDTH + LEVELS + 1;

  typedef logic signed [ACC_W-1:0] acc_t;

  // Number of live partial sums held at tree level l.
  function automatic int unsigned lvl_cnt(input int unsigned l);
    return (NUM_FEATURES + (32'd1 << l) - 32'd1) >> l;
  endfunction

  acc_t                            st_q [0:LEVELS-1][0:NUM_FEATURES-1];
  acc_t                            st_d [0:LEVELS-1][0:NUM_FEATURES-1];
  logic [LEVELS-1:0]               vld_q, vld_d;
  logic                            out_valid_q, out_valid_d;
  logic signed [FEATURE_WIDTH-1:0] feature_out_q, feature_out_d;
  logic                            sat_hit_d;
  acc_t                            sum;
  logic                            en;

  always_comb en = !(out_valid_q && !out_ready);

  always_comb begin
    acc_t ext;
    ext = '0;
    for (int unsigned l = 0; l < LEVELS; l++) begin
      for (int unsigned i = 0; i < NUM_FEATURES; i++) begin
        st_d[l][i] = '0;
      end
    end

    for (int unsigned i = 0; i < NUM_FEATURES; i++) begin
      ext        = {{(ACC_W-FEATURE_WIDTH){features_in[i][FEATURE_WIDTH-1]}}, features_in[i]};
      st_d[0][i] = SIGN_MASK[i] ? -ext : ext;
    end

    // Element j folds into slot j/2, so an unpaired last element passes through unchanged.
    for (int unsigned l = 1; l < LEVELS; l++) begin
      for (int unsigned j = 0; j < NUM_FEATURES; j++) begin
        if (j < lvl_cnt(l - 1)) begin
          st_d[l][j >> 1] = st_d[l][j >> 1] + st_q[l-1][j];
        end
      end
    end

    sum = '0;
    for (int unsigned j = 0; j < NUM_FEATURES; j++) begin
      if (j < lvl_cnt(LEVELS - 1)) begin
        sum = sum + st_q[LEVELS-1][j];
      end
    end

    vld_d[0] = in_valid;
    for (int unsigned l = 1; l < LEVELS; l++) begin
      vld_d[l] = vld_q[l-1];
    end
    out_valid_d = vld_q[LEVELS-1];

    sat_hit_d = 1'b0;
`ifdef FEATURE_REDUCE_SAT_EN
    if (sum > acc_t'({1'b0, {(FEATURE_WIDTH-1){1'b1}}})) begin
      feature_out_d = {1'b0, {(FEATURE_WIDTH-1){1'b1}}};
      sat_hit_d     = 1'b1;
    end else if (sum < -acc_t'({1'b1, {(FEATURE_WIDTH-1){1'b0}}})) begin
      feature_out_d = {1'b1, {(FEATURE_WIDTH-1){1'b0}}};
      sat_hit_d     = 1'b1;
    end else begin
      feature_out_d = sum[FEATURE_WIDTH-1:0];
    end
`else
    feature_out_d = sum[FEATURE_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (en) begin
      st_q <= st_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q         <= '0;
      out_valid_q   <= 1'b0;
      feature_out_q <= '0;
    end else if (en) begin
      vld_q         <= vld_d;
      out_valid_q   <= out_valid_d;
      feature_out_q <= feature_out_d;
    end
  end

`ifdef FEATURE_REDUCE_SAT_EN
  logic sat_hit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_hit_q <= 1'b0;
    end else if (en) begin
      sat_hit_q <= sat_hit_d;
    end
  end

  assign sat_hit = sat_hit_q;
`else
  assign sat_hit = 1'b0;
`endif

  assign in_ready    = en;
  assign out_valid   = out_valid_q;
  assign feature_out = feature_out_q;

endmodule

// File: tb/tb_feature_reduce_tree.sv
// Self-checking bench for feature_reduce_tree: directed table, stall/reset sequences and a randomized scoreboard.
module tb_feature_reduce_tree;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              out_ready;
  logic signed [15:0] fin [0:5];
  logic              in_ready,  out_valid,  sat_hit;
  logic              in_ready_z, out_valid_z, sat_hit_z;
  logic signed [15:0] feature_out, feature_out_z;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  feature_reduce_tree #(
    .FEATURE_WIDTH (16),
    .NUM_FEATURES  (6),
    .SIGN_MASK     (6'b000011)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .features_in (fin),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .feature_out (feature_out),
    .sat_hit     (sat_hit)
  );

  feature_reduce_tree #(
    .FEATURE_WIDTH (16),
    .NUM_FEATURES  (6),
    .SIGN_MASK     (6'b000000)
  ) dut_z (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready_z),
    .features_in (fin),
    .out_valid   (out_valid_z),
    .out_ready   (out_ready),
    .feature_out (feature_out_z),
    .sat_hit     (sat_hit_z)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer sum, then clamp or wrap to 16 bits.
  function automatic int model_sum(input int f[6], input logic [5:0] m);
    int s = 0;
    foreach (f[i]) s += m[i] ? -f[i] : f[i];
    return s;
  endfunction

  function automatic int nar_out(input int s);
`ifdef FEATURE_REDUCE_SAT_EN
    if (s > 32767)  return 32767;
    if (s < -32768) return -32768;
    return s;
`else
    int r = s % 65536;
    if (r > 32767)  r -= 65536;
    if (r < -32768) r += 65536;
    return r;
`endif
  endfunction

  function automatic int nar_sat(input int s);
`ifdef FEATURE_REDUCE_SAT_EN
    return (s > 32767 || s < -32768) ? 1 : 0;
`else
    return (s == s) ? 0 : 1;
`endif
  endfunction

  typedef struct { int oa; int sa; int oz; int sz; } exp_t;
  exp_t q[$];
  exp_t e;
  int   beats = 0;

  // Scoreboard: pushes accepted vectors, pops completed beats, checks held data during stalls.
  always @(negedge clk) begin
    int f[6];
    int s, sz;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = q.pop_front();
          chk("beat_out",   feature_out,   e.oa);
          chk("beat_sat",   sat_hit,       e.sa);
          chk("beat_out_z", feature_out_z, e.oz);
          chk("beat_sat_z", sat_hit_z,     e.sz);
          beats++;
        end
      end else if (out_valid) begin
        if (q.size() > 0) chk("stall_hold_out", feature_out, q[0].oa);
        chk("stall_in_ready", in_ready, 0);
      end
      if (in_valid && in_ready) begin
        foreach (f[i]) f[i] = int'(fin[i]);
        s  = model_sum(f, 6'b000011);
        sz = model_sum(f, 6'b000000);
        q.push_back('{nar_out(s), nar_sat(s), nar_out(sz), nar_sat(sz)});
      end
    end
  end

  function automatic int rand_feat();
    case ($urandom_range(0, 3))
      0:       return -32768;
      1:       return 32767;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  // Starts at posedge+#1; drives n vectors honouring in_ready; returns the cycles spent.
  task automatic send_stream(input int n, input int gap_pct, output int cyc);
    int sent = 0;
    bit x;
    cyc = 0;
    while (sent < n && cyc < 5000) begin
      if (!in_valid && $urandom_range(0, 99) >= gap_pct) begin
        foreach (fin[i]) fin[i] = 16'(rand_feat());
        in_valid = 1'b1;
      end
      @(negedge clk);
      x = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (x) begin
        in_valid = 1'b0;
        sent++;
      end
      cyc++;
    end
    if (sent < n) chk("send_timeout", sent, n);
  endtask

  task automatic drain();
    int g = 0;
    while (q.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("drain_empty", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  typedef struct { int f[6]; int ea; int sa; int ez; int sz; } vec_t;
  vec_t tbl[6];

  task automatic apply_vec(input int k);
    int lat = 0;
    foreach (fin[i]) fin[i] = 16'(tbl[k].f[i]);
    in_valid = 1'b1;
    @(negedge clk);
    chk("vec_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("vec_latency", lat, 4);
    chk("vec_out",   feature_out,   tbl[k].ea);
    chk("vec_sat",   sat_hit,       tbl[k].sa);
    chk("vec_out_z", feature_out_z, tbl[k].ez);
    chk("vec_sat_z", sat_hit_z,     tbl[k].sz);
    @(posedge clk);
    #1;
  endtask

  bit rnd_done;

  initial begin
    int cyc, b0, g, held, ghosts;

    tbl[0] = '{'{1, 2, 3, 4, 5, 6}, 15, 0, 21, 0};
    tbl[3] = '{'{100, -50, 7, -8, 0, 1000}, 949, 0, 1049, 0};
    tbl[4] = '{'{0, 0, 32767, 0, 0, 0}, 32767, 0, 32767, 0};
`ifdef FEATURE_REDUCE_SAT_EN
    tbl[1] = '{'{-32768, -32768, 32767, 32767, 32767, 32767}, 32767, 1, 32767, 1};
    tbl[2] = '{'{-32768, -32768, -32768, -32768, -32768, -32768}, -32768, 1, -32768, 1};
    tbl[5] = '{'{-32768, 0, 0, 0, 0, 0}, 32767, 1, -32768, 0};
`else
    tbl[1] = '{'{-32768, -32768, 32767, 32767, 32767, 32767}, -4, 0, -4, 0};
    tbl[2] = '{'{-32768, -32768, -32768, -32768, -32768, -32768}, 0, 0, 0, 0};
    tbl[5] = '{'{-32768, 0, 0, 0, 0, 0}, -32768, 0, -32768, 0};
`endif

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    foreach (fin[i]) fin[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_feature",   feature_out, 0);
    chk("reset_sat",       sat_hit, 0);
    chk("reset_in_ready",  in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 6; k++) apply_vec(k);

    // Back-to-back: four vectors in four cycles, four beats out.
    b0 = beats;
    send_stream(4, 0, cyc);
    chk("b2b_cycles", cyc, 4);
    drain();
    chk("b2b_beats", beats - b0, 4);

    // Stall three cycles once the first result is presented.
    b0 = beats;
    fork
      send_stream(6, 0, cyc);
      begin
        g = 0;
        while (!out_valid && g < 20) begin
          @(negedge clk);
          g++;
        end
        chk("stall_reach", out_valid, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        held = feature_out;
        repeat (3) @(posedge clk);
        chk("stall_held", feature_out, held);
        chk("stall_ready_low", in_ready, 0);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_beats", beats - b0, 6);

    // Randomized traffic with random backpressure.
    b0 = beats;
    rnd_done = 1'b0;
    fork
      begin
        send_stream(60, 30, cyc);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    chk("rand_beats", beats - b0, 60);

    // Reset with vectors in flight.
    send_stream(3, 0, cyc);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_out",   feature_out, 0);
    repeat (2) @(negedge clk);
    chk("rst_hold_valid", out_valid, 0);
    chk("rst_hold_out",   feature_out, 0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    ghosts = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) ghosts++;
    end
    chk("rst_no_ghost", ghosts, 0);
    @(posedge clk);
    #1;
    apply_vec(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule
